glyph_scroll_ctrl: RTL and testbench

Sequencer that drives the 5-bit glyph-code to 7-segment decoder in a multiplexed, scrolling multi-digit display. It holds a small message buffer of 5-bit glyph codes. It time-multiplexes one shared decoder across `DIGITS` digit positions and advances the visible window through the message at a fixed rate, wrapping around. It sits between the host or register interface and the decoder. Its `code` output feeds the decoder's 5-bit input, and `dig_en` selects the digit that is currently lit.

---
 rtl/glyph_scroll_ctrl.sv | 178 +++++++++++++++++
 tb/tb_glyph_scroll_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/glyph_scroll_ctrl.sv
// Scrolling multiplexed display sequencer. It holds a glyph message buffer and
// time-shares one 7-segment decoder across DIGITS positions with a wrapping scroll window.
module glyph_scroll_ctrl #(
    parameter int          DIGITS       = 4,
    parameter int          MSG_DEPTH    = 16,
    parameter int          REFRESH_DIV  = 1000,
    parameter int          SCROLL_TICKS = 64,
    parameter logic [4:0]  BLANK_CODE   = 5'b11111,
    localparam int         AW           = $clog2(MSG_DEPTH),
    localparam int         LW           = $clog2(MSG_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    input  logic [LW-1:0]     len,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [4:0]        code,
    output logic [DIGITS-1:0] dig_en,
    output logic              step
);

    localparam int SW = $clog2(DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int FW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam int IW = LW + 4;

    localparam logic [AW-1:0]     AW_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]     LW_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     SW_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]     RW_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0]     FW_ONE  = {{(FW-1){1'b0}}, 1'b1};
    localparam logic [DIGITS-1:0] DIG_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [RW-1:0]   rc_r, rc_s;
    logic [SW-1:0]   slot_r, slot_s;
    logic [FW-1:0]   fc_r, fc_s;
    logic [AW-1:0]   pos_r, pos_s;
    logic [LW-1:0]   len_q_r, len_q_s;
    logic            adv_s;
    logic [IW-1:0]   sum_s;
    logic [4:0]      buf_r [MSG_DEPTH];
    logic [4:0]      code_r, code_s;
    logic [DIGITS-1:0] dig_en_r, dig_en_s;
    logic            step_r, step_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and counter chain: stop beats start beats counting
    always_comb begin
        state_s = state_r;
        rc_s    = rc_r;
        slot_s  = slot_r;
        fc_s    = fc_r;
        pos_s   = pos_r;
        len_q_s = len_q_r;
        adv_s   = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
        end else if (start) begin
            rc_s   = '0;
            slot_s = '0;
            fc_s   = '0;
            pos_s  = '0;
            if (len != '0) begin
                state_s = ST_RUN;
                len_q_s = (len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : len;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (state_r == ST_RUN) begin
            if (rc_r == RW'(REFRESH_DIV - 1)) begin
                rc_s = '0;
                if (slot_r == SW'(DIGITS - 1)) begin
                    slot_s = '0;
                    if (fc_r == FW'(SCROLL_TICKS - 1)) begin
                        fc_s  = '0;
                        adv_s = 1'b1;
                        if ((LW'(pos_r) + LW_ONE) == len_q_r) begin
                            pos_s = '0;
                        end else begin
                            pos_s = pos_r + AW_ONE;
                        end
                    end else begin
                        fc_s = fc_r + FW_ONE;
                    end
                end else begin
                    slot_s = slot_r + SW_ONE;
                end
            end else begin
                rc_s = rc_r + RW_ONE;
            end
        end else begin
            state_s = ST_IDLE;
        end
    end

    // Message index (pos + slot) mod len_q by repeated subtraction; short messages need several passes
    always_comb begin
        sum_s = IW'(pos_s) + IW'(slot_s);
        for (int i = 0; i < DIGITS; i++) begin
            if (sum_s >= IW'(len_q_s)) begin
                sum_s = sum_s - IW'(len_q_s);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs align with it
    always_comb begin
        code_s   = BLANK_CODE;
        dig_en_s = '0;
        step_s   = 1'b0;
        if (state_s == ST_RUN) begin
            dig_en_s = DIG_ONE << slot_s;
            step_s   = adv_s;
            for (int i = 0; i < MSG_DEPTH; i++) begin
                if (sum_s == IW'(i)) begin
                    code_s = buf_r[i];
                end else begin
                    code_s = code_s;
                end
            end
        end else begin
            code_s = BLANK_CODE;
        end
    end

    // Counters and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_r     <= '0;
            slot_r   <= '0;
            fc_r     <= '0;
            pos_r    <= '0;
            len_q_r  <= '0;
            code_r   <= BLANK_CODE;
            dig_en_r <= '0;
            step_r   <= 1'b0;
        end else begin
            rc_r     <= rc_s;
            slot_r   <= slot_s;
            fc_r     <= fc_s;
            pos_r    <= pos_s;
            len_q_r  <= len_q_s;
            code_r   <= code_s;
            dig_en_r <= dig_en_s;
            step_r   <= step_s;
        end
    end

    // Message buffer: intentionally not reset, writable in any state
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_r[wr_addr] <= wr_data;
        end
    end

    assign busy   = (state_r == ST_RUN);
    assign code   = code_r;
    assign dig_en = dig_en_r;
    assign step   = step_r;

endmodule

// File: tb/tb_glyph_scroll_ctrl.sv
// Bench for glyph_scroll_ctrl: an elapsed-time model of the scroll window checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_glyph_scroll_ctrl;

    localparam int D = 4;
    localparam int R = 4;
    localparam int S = 2;
    localparam int M = 16;
    localparam int FRAME_STEP = R * D * S;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [4:0] wr_data = 5'd0;
    logic [4:0] len = 5'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic [4:0] code;
    logic [3:0] dig_en;
    logic       step;

    int n_cmp = 0;
    int n_bad = 0;

    glyph_scroll_ctrl #(
        .DIGITS(D), .MSG_DEPTH(M), .REFRESH_DIV(R), .SCROLL_TICKS(S), .BLANK_CODE(5'b11111)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .busy(busy), .code(code),
        .dig_en(dig_en), .step(step)
    );

    always #5 clk = ~clk;

    // Model: elapsed cycles since start determine slot and scroll position directly
    logic       m_run = 1'b0;
    int         m_t = 0;
    int         m_lenq = 1;
    int         m_slot = 0;
    logic [4:0] m_code = 5'h1f;
    logic       m_step = 1'b0;
    logic [4:0] mbuf [M];

    always @(posedge clk or negedge rst_n) begin : model
        logic run_n;
        int   t_n, lq_n, sl, ps;
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_t    <= 0;
            m_code <= 5'h1f;
            m_step <= 1'b0;
            m_slot <= 0;
        end else begin
            run_n = m_run;
            t_n   = m_t;
            lq_n  = m_lenq;
            if (stop) begin
                run_n = 1'b0;
            end else if (start) begin
                if (len != 5'd0) begin
                    run_n = 1'b1;
                    t_n   = 0;
                    lq_n  = (int'(len) > M) ? M : int'(len);
                end else begin
                    run_n = 1'b0;
                end
            end else if (m_run) begin
                t_n = m_t + 1;
            end
            m_run  <= run_n;
            m_t    <= t_n;
            m_lenq <= lq_n;
            if (run_n) begin
                sl = (t_n / R) % D;
                ps = (t_n / FRAME_STEP) % lq_n;
                m_slot <= sl;
                m_code <= mbuf[(ps + sl) % lq_n];
                m_step <= (t_n > 0) && (t_n % FRAME_STEP == 0);
            end else begin
                m_code <= 5'h1f;
                m_step <= 1'b0;
            end
            if (wr_en) mbuf[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin : compare
        logic [3:0] exp_dig;
        exp_dig = m_run ? (4'b0001 << m_slot) : 4'b0000;
        check("model_busy", {31'd0, busy}, {31'd0, m_run});
        check("model_dig_en", {28'd0, dig_en}, {28'd0, exp_dig});
        check("model_code", {27'd0, code}, {27'd0, m_code});
        check("model_step", {31'd0, step}, {31'd0, m_step});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l);
        len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        cyc(2);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dig_en", {28'd0, dig_en}, 32'd0);
        check("reset_code", {27'd0, code}, 32'h1f);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < M; i++) wr(4'(i), 5'(i));

        // Basic scan, len 6
        go(5'd6);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_dig", {28'd0, dig_en}, 32'h1);
        check("start_code", {27'd0, code}, 32'h00);
        cyc(4);  check("slot1_dig", {28'd0, dig_en}, 32'h2);
                 check("slot1_code", {27'd0, code}, 32'h01);
        cyc(4);  check("slot2_code", {27'd0, code}, 32'h02);
        cyc(4);  check("slot3_dig", {28'd0, dig_en}, 32'h8);
                 check("slot3_code", {27'd0, code}, 32'h03);
        cyc(20); check("step1_pulse", {31'd0, step}, 32'd1);
                 check("step1_code", {27'd0, code}, 32'h01);
        cyc(1);  check("step1_end", {31'd0, step}, 32'd0);
        cyc(3);  check("pos1_slot1", {27'd0, code}, 32'h02);

        // Wrap-around at pos 5
        cyc(124); check("pos5_slot0", {27'd0, code}, 32'h05);
        cyc(4);   check("pos5_slot1", {27'd0, code}, 32'h00);
        cyc(28);  check("pos0_again", {27'd0, code}, 32'h00);
                  check("pos0_step", {31'd0, step}, 32'd1);

        // Short message and zero-length start
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        wr(4'd0, 5'h10); wr(4'd1, 5'h11);
        go(5'd2);
        cyc(8);  check("short_slot2", {27'd0, code}, 32'h10);
        cyc(4);  check("short_slot3", {27'd0, code}, 32'h11);
        go(5'd0); check("len0_run_busy", {31'd0, busy}, 32'd0);
        go(5'd0); check("len0_idle_busy", {31'd0, busy}, 32'd0);
                  check("len0_idle_dig", {28'd0, dig_en}, 32'd0);

        // Live write and control priority
        go(5'd6);
        cyc(1);
        wr(4'd1, 5'h13);
        cyc(2);  check("live_write", {27'd0, code}, 32'h13);
        len = 5'd6; start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check("stop_wins_busy", {31'd0, busy}, 32'd0);
        check("stop_wins_code", {27'd0, code}, 32'h1f);
        go(5'd6);
        cyc(10);
        go(5'd6);
        check("restart_dig", {28'd0, dig_en}, 32'h1);
        check("restart_code", {27'd0, code}, 32'h10);

        // Length 16 and clamp of oversize len
        for (int i = 0; i < M; i++) wr(4'(i), 5'(i));
        go(5'd16);
        cyc(480); check("len16_pos15", {27'd0, code}, 32'h0f);
        cyc(4);   check("len16_wrap_idx", {27'd0, code}, 32'h00);
        cyc(28);  check("len16_pos0", {27'd0, code}, 32'h00);
                  check("len16_step", {31'd0, step}, 32'd1);
        go(5'd31);
        cyc(480); check("clamp_pos15", {27'd0, code}, 32'h0f);
        cyc(32);  check("clamp_pos0", {27'd0, code}, 32'h00);

        // Asynchronous reset mid-run
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_dig", {28'd0, dig_en}, 32'd0);
        check("async_code", {27'd0, code}, 32'h1f);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
